instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the single-cycle R-type datapath.
- Holds the PC and a word-addressed instruction ROM. It presents one 32-bit instruction per cycle on a valid/ready handshake, and that output drives the datapath's instruction input.
- Supports PC redirect (jump/branch target), backpressure from the datapath, and end-of-program detection.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in the instruction ROM; program image loaded by bench via $readmemb into the array.
- RESET_PC, 32'h0000_0000, PC value after reset (byte address, word aligned).
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_ready  in  1  datapath accepts instr_out this cycle.
- redirect_en  in  1  load redirect_pc into PC and flush the output.
- redirect_pc  in  32  byte-address target; bits [1:0] ignored (forced 0).
- instr_valid  out  1  instr_out/pc_out hold a valid instruction.
- instr_out  out  32  fetched instruction word (feeds OPcode/rs/rt/rd/funct fields downstream).
- pc_out  out  32  byte address of instr_out.
- done  out  1  PC has run past the last ROM word; no further fetches.
- fetch_count  out  CNT_W  number of handshakes completed (valid && ready) since reset.

Behaviour:
- Reset is synchronous, active-high, and takes effect on the clock edge where rst=1, overriding all other inputs. It can be applied mid-operation. Reset values:
  - state=S_IDLE, pc=RESET_PC, instr_valid=0, instr_out=0, pc_out=0, done=0, fetch_count=0.
- Word index = pc[log2(IMEM_DEPTH)+1:2]. ROM read is combinational on the index; the result is captured into the output register.
- "load" condition: state==S_FETCH && (!instr_valid || instr_ready) && !redirect_en.
- State S_IDLE: one-cycle settle. Next state S_FETCH; outputs unchanged from reset.
- State S_FETCH:
  - On load with pc < IMEM_DEPTH*4: instr_out<=imem[index], pc_out<=pc, instr_valid<=1, pc<=pc+4.
  - On load with pc >= IMEM_DEPTH*4: instr_valid<=0, done<=1, state->S_DONE.
  - No load (valid && !ready): instr_out, pc_out, instr_valid and pc all hold. Outputs must be stable while stalled.
- State S_DONE: instr_valid=0, done=1, pc holds; stays until redirect_en or rst.
- Redirect (any state except during rst):
  - pc<={redirect_pc[31:2],2'b00}, instr_valid<=0 (the pending instruction is discarded even if instr_ready=1 that cycle), done<=0, state->S_FETCH.
  - First redirected instruction is valid on the cycle after the redirect edge.
  - Redirect has priority over load.
- fetch_count increments by 1 on every cycle with instr_valid && instr_ready && !redirect_en. It wraps modulo 2^CNT_W and is cleared only by rst.
- Latency:
  - rst deassert edge -> S_IDLE (1 cycle) -> first load edge -> instr_valid=1 at the 2nd rising edge after rst drops.
  - Steady state with instr_ready=1: one instruction per cycle, pc_out advancing by 4.
- pc arithmetic: 32-bit unsigned, wraps at 2^32 (unreachable for legal IMEM_DEPTH; no special handling).
- No X on any output after reset. Contents of unloaded ROM words are the bench's responsibility.

Decomposition:
- Shared package holds:
  - state enum {S_IDLE, S_FETCH, S_DONE} (2 bits);
  - INSTR_W=32;
  - PC_STEP=4;
  - R-type field positions (opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0), shared with the decode/control side.
- One natural sub-module: instr_rom (IMEM_DEPTH x 32 array, combinational read, $readmemb-loadable). The FSM, PC and output register stay in instr_fetch.

Test Plan:
1. ROM[0]=32'h0001_1020 (add $2,$0,$1), ROM[1]=32'h0022_1822, ready=1, rst held 2 cycles then dropped.
   -> 2nd edge after release: valid=1, instr_out=0x00011020, pc_out=0. Next cycle: 0x00221822, pc_out=4. fetch_count=2 after two accepts.
2. Backpressure: ready=0 for 3 cycles while valid=1 at pc_out=8.
   -> instr_out/pc_out constant for all 3 cycles, fetch_count unchanged. When ready=1, pc_out=12 appears next cycle.
3. Redirect: redirect_en=1, redirect_pc=32'h0000_0013 while valid=1, ready=1, pc_out=4.
   -> next cycle valid=0 and fetch_count not incremented. Following cycle pc_out=0x10, instr_out=ROM[4].
4. End of ROM with IMEM_DEPTH=4, ready=1: words at pc_out=0,4,8,12 delivered.
   -> then valid=0, done=1, held for 10 cycles. Redirect to 0 clears done; pc_out=0 valid one cycle later.
5. Reset mid-stream: rst=1 for one cycle while valid=1, pc_out=20, ready=0.
   -> next cycle valid=0, done=0, fetch_count=0, pc_out=0. Re-fetch of ROM[0] with the same 2-cycle latency as scenario 1.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage and the decode/control side.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  // R-type field positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  function automatic rtype_t split_rtype(input logic [INSTR_W-1:0] instr);
    return rtype_t'(instr);
  endfunction

endpackage

// File: rtl/instr_fetch_rom.sv
// Word-addressed instruction ROM; contents are loaded from outside (image file or bench).
module instr_rom
  import instr_fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic [AW-1:0]      addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  assign data = mem[addr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, ROM lookup and a registered valid/ready output feeding the datapath.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_ready,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        pc_out,
  output logic               done,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam int          AW       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * PC_STEP);

  state_t             state;
  logic [31:0]        pc;
  logic [AW-1:0]      idx;
  logic [INSTR_W-1:0] rom_data;
  logic               load;
  logic               unused_bits;

  assign idx         = pc[AW+1:2];
  assign unused_bits = ^redirect_pc[1:0];
  // An instruction held while stalled must not be replaced, so load waits for the slot to drain.
  assign load        = (state == S_FETCH) && (!instr_valid || instr_ready) && !redirect_en;

  instr_rom #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW)) u_rom (
    .addr (idx),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      done        <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (instr_valid && instr_ready && !redirect_en)
        fetch_count <= fetch_count + 1'b1;

      // Redirect wins over everything, discarding whatever is on the output.
      if (redirect_en) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        instr_valid <= 1'b0;
        done        <= 1'b0;
        state       <= S_FETCH;
      end else begin
        case (state)
          S_IDLE:  state <= S_FETCH;
          S_FETCH: begin
            if (load) begin
              if (pc < PC_LIMIT) begin
                instr_out   <= rom_data;
                pc_out      <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'(PC_STEP);
              end else begin
                instr_valid <= 1'b0;
                done        <= 1'b1;
                state       <= S_DONE;
              end
            end
          end
          S_DONE:  begin
            instr_valid <= 1'b0;
            done        <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, end-of-ROM sequence, randomized run vs. a reference model.
module tb_instr_fetch;

  localparam int DEPTH  = 64;
  localparam int DEPTH4 = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, ren;
  logic [31:0] rpc;
  logic        v;
  logic [31:0] instr, pco;
  logic        dn;
  logic [15:0] cnt;

  logic        rst4, rdy4, ren4;
  logic [31:0] rpc4;
  logic        v4;
  logic [31:0] instr4, pco4;
  logic        dn4;
  logic [15:0] cnt4;

  instr_fetch #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_ready(rdy), .redirect_en(ren), .redirect_pc(rpc),
    .instr_valid(v), .instr_out(instr), .pc_out(pco), .done(dn), .fetch_count(cnt)
  );

  instr_fetch #(.IMEM_DEPTH(DEPTH4)) dut4 (
    .clk(clk), .rst(rst4), .instr_ready(rdy4), .redirect_en(ren4), .redirect_pc(rpc4),
    .instr_valid(v4), .instr_out(instr4), .pc_out(pco4), .done(dn4), .fetch_count(cnt4)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] img(input int i);
    if (i == 0) return 32'h0001_1020;
    if (i == 1) return 32'h0022_1822;
    return 32'h1000_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          r, rd, re;
    logic [31:0] rp;
    bit          ev, ed;
    logic [31:0] epc, ei;
    int          ec;
    bit          cd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit rd, bit re, logic [31:0] rp, bit ev, bit ed,
                              logic [31:0] epc, logic [31:0] ei, int ec, bit cd);
    vec_t x;
    x.r = r; x.rd = rd; x.re = re; x.rp = rp; x.ev = ev; x.ed = ed;
    x.epc = epc; x.ei = ei; x.ec = ec; x.cd = cd;
    return x;
  endfunction

  // Reference model: the output slot plus the next address to fetch.
  bit          m_warm, m_done, m_v;
  logic [31:0] m_next, m_pc, m_instr;
  int unsigned m_cnt;

  task automatic model_step(input bit r, input bit rd, input bit re, input logic [31:0] rp);
    if (r) begin
      m_warm = 0; m_done = 0; m_v = 0; m_next = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
    end else begin
      if (m_v && rd && !re) m_cnt = (m_cnt + 1) % 65536;
      if (re) begin
        m_next = rp & ~32'd3; m_v = 0; m_done = 0; m_warm = 1;
      end else if (!m_warm) begin
        m_warm = 1;
      end else if (!m_done && (!m_v || rd)) begin
        if (m_next < DEPTH * 4) begin
          m_pc = m_next; m_instr = img(int'(m_next / 4)); m_v = 1; m_next = m_next + 4;
        end else begin
          m_v = 0; m_done = 1;
        end
      end
    end
  endtask

  initial begin
    rst = 1; rdy = 1; ren = 0; rpc = 0;
    rst4 = 1; rdy4 = 1; ren4 = 0; rpc4 = 0;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = img(i);
    for (int i = 0; i < DEPTH4; i++) dut4.u_rom.mem[i] = img(i);

    // reset/start, backpressure, mid-stream reset, redirect
    tbl.push_back(mk(1,1,0,0, 0,0, 0,0, 0,1));
    tbl.push_back(mk(1,1,0,0, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 0,img(0), 0,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 4,img(1), 1,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 8,img(2), 2,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 8,img(2), 2,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 8,img(2), 2,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 8,img(2), 2,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 12,img(3), 3,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 16,img(4), 4,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 20,img(5), 5,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 20,img(5), 5,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 0,img(0), 0,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 4,img(1), 1,1));
    tbl.push_back(mk(0,1,1,32'h13, 0,0, 0,0, 1,0));
    tbl.push_back(mk(0,1,0,0, 1,0, 32'h10,img(4), 1,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 32'h14,img(5), 2,1));

    #2;
    foreach (tbl[k]) begin
      rst = tbl[k].r; rdy = tbl[k].rd; ren = tbl[k].re; rpc = tbl[k].rp;
      tick();
      chk($sformatf("vec%0d_valid", k), {31'd0, v}, {31'd0, tbl[k].ev});
      chk($sformatf("vec%0d_done", k), {31'd0, dn}, {31'd0, tbl[k].ed});
      chk($sformatf("vec%0d_count", k), {16'd0, cnt}, 32'(tbl[k].ec));
      if (tbl[k].cd) begin
        chk($sformatf("vec%0d_pc", k), pco, tbl[k].epc);
        chk($sformatf("vec%0d_instr", k), instr, tbl[k].ei);
      end
    end
    ren = 0;

    // end of a 4-word ROM, done hold, redirect out of done
    tick();
    chk("rom4_rst_valid", {31'd0, v4}, 32'd0);
    rst4 = 0;
    tick();
    chk("rom4_idle_valid", {31'd0, v4}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rom4_w%0d_valid", k), {31'd0, v4}, 32'd1);
      chk($sformatf("rom4_w%0d_pc", k), pco4, 32'(k * 4));
      chk($sformatf("rom4_w%0d_instr", k), instr4, img(k));
      chk($sformatf("rom4_w%0d_done", k), {31'd0, dn4}, 32'd0);
    end
    for (int k = 0; k < 11; k++) begin
      tick();
      chk($sformatf("rom4_end%0d_valid", k), {31'd0, v4}, 32'd0);
      chk($sformatf("rom4_end%0d_done", k), {31'd0, dn4}, 32'd1);
      chk($sformatf("rom4_end%0d_count", k), {16'd0, cnt4}, 32'd4);
    end
    ren4 = 1; rpc4 = 0;
    tick();
    chk("rom4_redir_done", {31'd0, dn4}, 32'd0);
    chk("rom4_redir_valid", {31'd0, v4}, 32'd0);
    ren4 = 0;
    tick();
    chk("rom4_refetch_valid", {31'd0, v4}, 32'd1);
    chk("rom4_refetch_pc", pco4, 32'd0);
    chk("rom4_refetch_instr", instr4, img(0));

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rst = (n == 0) || ($urandom_range(63) == 0);
      ren = ($urandom_range(9) == 0);
      rpc = $urandom_range(DEPTH * 4 + 12);
      rdy = ($urandom_range(9) < 7);
      model_step(rst, rdy, ren, rpc);
      tick();
      chk($sformatf("rnd%0d_valid", n), {31'd0, v}, {31'd0, m_v});
      chk($sformatf("rnd%0d_done", n), {31'd0, dn}, {31'd0, m_done});
      chk($sformatf("rnd%0d_count", n), {16'd0, cnt}, m_cnt);
      if (m_v) begin
        chk($sformatf("rnd%0d_pc", n), pco, m_pc);
        chk($sformatf("rnd%0d_instr", n), instr, m_instr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
